bcd_countdown_timer: RTL and testbench

Multi-digit BCD countdown that consumes the one-cycle, one-second tick pulses produced by the tick-generation chain. It decrements a loaded BCD value once per accepted tick, with borrow across digits. It drives the digit outputs for the display and flags expiry to the game control logic. Sits downstream of the second-tick generator, on the receiving end of its tick interface.

---
 rtl/bcd_countdown_timer.sv | 131 +++++++++++++
 tb/tb_bcd_countdown_timer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown driven by one-second tick pulses.
// Optional auto-reload on expiry when COUNTDOWN_AUTORELOAD_EN is defined.
module bcd_countdown_timer #(
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    tick_in,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] count_out,
  output logic                    running,
  output logic                    expired,
  output logic                    timeout
);

  localparam int W = 4 * NUM_DIGITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_EXP  = 2'd2;

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO = '0;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         timeout_q, timeout_d;
  logic [W-1:0] ld_san;
  logic [W-1:0] dec_val;
  logic         tick_ok;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [W-1:0] shadow_q, shadow_d;
`endif

  // Clamp each preset digit above 9 down to 9
  always_comb begin
    ld_san = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9)
        ld_san[4*i +: 4] = 4'd9;
      else
        ld_san[4*i +: 4] = load_val[4*i +: 4];
    end
  end

  // Ripple-borrow BCD decrement of the current count
  always_comb begin
    logic borrow;
    dec_val = count_q;
    borrow  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  assign tick_ok = (state_q == S_RUN) && en && tick_in;

  // Next-state: load wins, then accepted ticks in RUN
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timeout_d = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    shadow_d  = shadow_q;
`endif
    if (load) begin
      count_d = ld_san;
      state_d = (ld_san == ZERO) ? S_EXP : S_RUN;
`ifdef COUNTDOWN_AUTORELOAD_EN
      shadow_d = ld_san;
`endif
    end else if (tick_ok) begin
      if (count_q == ONE) begin
        timeout_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
        if (shadow_q != ZERO) begin
          count_d = shadow_q;
          state_d = S_RUN;
        end else begin
          count_d = ZERO;
          state_d = S_EXP;
        end
`else
        count_d = ZERO;
        state_d = S_EXP;
`endif
      end else begin
        count_d = dec_val;
      end
    end
  end

  // State, count and pulse registers with async active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef COUNTDOWN_AUTORELOAD_EN
  // Shadow copy of the last sanitised preset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      shadow_q <= '0;
    else
      shadow_q <= shadow_d;
  end
`endif

  assign count_out = count_q;
  assign running   = (state_q == S_RUN);
  assign expired   = (state_q == S_EXP);
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Randomized bench for bcd_countdown_timer against a decimal-arithmetic model.
// Model honours COUNTDOWN_AUTORELOAD_EN when it is defined.
module tb_bcd_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       tick_in;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count_out;
  logic       running;
  logic       expired;
  logic       timeout;

  logic        en3;
  logic        tk3;
  logic        ld3;
  logic [11:0] lv3;
  logic [11:0] cnt3;
  logic        run3;
  logic        exp3;
  logic        to3;

  int n_tests;
  int n_fail;

  int m_cnt;
  int m_st;
  int m_shadow;
  bit m_to;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_EXP  = 2;

  bcd_countdown_timer #(.NUM_DIGITS(2)) u_dut (
    .clk(clk), .reset(rst_n), .en(en), .tick_in(tick_in),
    .load(load), .load_val(load_val), .count_out(count_out),
    .running(running), .expired(expired), .timeout(timeout)
  );

  bcd_countdown_timer #(.NUM_DIGITS(3)) u_dut3 (
    .clk(clk), .reset(rst_n), .en(en3), .tick_in(tk3),
    .load(ld3), .load_val(lv3), .count_out(cnt3),
    .running(run3), .expired(exp3), .timeout(to3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int san(input logic [7:0] lv);
    int v;
    int d;
    v = 0;
    for (int i = 0; i < 2; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * ((i == 0) ? 1 : 10);
    end
    return v;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[3:0] = 4'(v % 10);
    r[7:4] = 4'((v / 10) % 10);
    return r;
  endfunction

  task automatic m_reset();
    m_cnt = 0;
    m_st = M_IDLE;
    m_shadow = 0;
    m_to = 0;
  endtask

  task automatic m_step(input bit l, input logic [7:0] lv,
                        input bit t, input bit e);
    int v;
    m_to = 0;
    if (l) begin
      v = san(lv);
      m_shadow = v;
      m_cnt = v;
      m_st = (v == 0) ? M_EXP : M_RUN;
    end else if (m_st == M_RUN && t && e) begin
      if (m_cnt == 1) begin
        m_to = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
        if (m_shadow != 0) begin
          m_cnt = m_shadow;
        end else begin
          m_cnt = 0;
          m_st = M_EXP;
        end
`else
        m_cnt = 0;
        m_st = M_EXP;
`endif
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic cmp_all();
    chk("cnt", 32'(count_out), 32'(to_bcd(m_cnt)));
    chk("run", 32'(running), 32'(m_st == M_RUN));
    chk("exp", 32'(expired), 32'(m_st == M_EXP));
    chk("to", 32'(timeout), 32'(m_to));
  endtask

  // Called from a negedge: drive, clock, update model, compare
  task automatic cyc(input bit l, input logic [7:0] lv,
                     input bit t, input bit e);
    load = l;
    load_val = lv;
    tick_in = t;
    en = e;
    @(posedge clk);
    m_step(l, lv, t, e);
    @(negedge clk);
    cmp_all();
  endtask

  int to_seen;

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    en = 0; tick_in = 0; load = 0; load_val = '0;
    en3 = 0; tk3 = 0; ld3 = 0; lv3 = '0;
    m_reset();
    repeat (2) @(negedge clk);
    cmp_all();
    rst_n = 1'b1;
    cyc(0, 8'h00, 1, 1);

    // Count down from 12 with widely spaced ticks
    cyc(1, 8'h12, 0, 1);
    to_seen = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(0, 8'h00, 1, 1);
      if (timeout) to_seen++;
      repeat (4) begin
        cyc(0, 8'h00, 0, 1);
        if (timeout) to_seen++;
      end
    end
    chk("t1_to_cnt", 32'(to_seen), 32'd1);
`ifndef COUNTDOWN_AUTORELOAD_EN
    chk("t1_zero", 32'(count_out), 32'h00);
`endif
    cyc(0, 8'h00, 1, 1);

    // Borrow across digits and pause
    cyc(1, 8'h10, 0, 1);
    cyc(0, 8'h00, 1, 1);
    chk("t2_borrow", 32'(count_out), 32'h09);
    repeat (3) begin
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 0);
    end
    cyc(0, 8'h00, 1, 1);
    chk("t2_resume", 32'(count_out), 32'h08);

    // Clamp and zero load
    cyc(1, 8'hAF, 0, 1);
    chk("t3_clamp", 32'(count_out), 32'h99);
    cyc(1, 8'h00, 1, 1);
    repeat (3) cyc(0, 8'h00, 1, 1);

    // Load collides with tick, then async reset mid-count
    cyc(1, 8'h05, 1, 1);
    chk("t4_ld_tick", 32'(count_out), 32'h05);
    cyc(0, 8'h00, 1, 1);
    @(posedge clk);
    m_step(0, 8'h00, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("t4_async_cnt", 32'(count_out), 32'h00);
    chk("t4_async_run", 32'(running), 32'd0);
    @(negedge clk);
    cmp_all();
    rst_n = 1'b1;
    cyc(0, 8'h00, 1, 1);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom % 16) == 0, 8'($urandom),
          ($urandom % 3) == 0, ($urandom % 4) != 0);
    end

    // Three-digit instance borrow
    ld3 = 1; lv3 = 12'h100; en3 = 1;
    @(posedge clk);
    @(negedge clk);
    ld3 = 0; tk3 = 1;
    @(posedge clk);
    @(negedge clk);
    tk3 = 0;
    chk("t6_w3", 32'(cnt3), 32'h099);
    chk("t6_w3_run", 32'(run3), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
